// File: rtl/z80_bus_decoder.sv
// Z80 bus cycle recorder. Classifies each strobe cycle, measures its length and wait states,
// and queues one record per cycle in a 4-entry FIFO.

// sync_fifo: generic synchronous FIFO. DEPTH must be a power of two.
// Latency: a push is visible on out_* after the edge that writes it.
// Backpressure: in_rdy is low only when full and no pop on the same edge.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign out_vld = (count != '0);
    assign in_rdy  = (count != FULL_CNT) || out_rdy;
    assign out_dat = mem[rd_ptr];
    assign do_pop  = out_vld && out_rdy;
    assign do_push = in_vld && in_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= in_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// z80_bus_decoder: records one entry per Z80 memory/IO strobe cycle.
// Latency: record becomes REC_VALID one edge after the strobe is first sampled high.
// Backpressure: REC_READY pops the head; pushes into a full FIFO are dropped and flag OVF.
module z80_bus_decoder (
    input  logic        B_PHI,
    input  logic        RST,
    input  logic        BMREQ_N,
    input  logic        IORQ_N,
    input  logic        BRD_N,
    input  logic        N_BWR,
    input  logic        BM1_N,
    input  logic        BRFSH_N,
    input  logic        WAIT_N,
    input  logic        DMA_N,
    input  logic        BA15,
    input  logic        BA14,
    input  logic        BA13,
    input  logic        BA7,
    input  logic        BA6,
    input  logic        BD0,
    input  logic        BD1,
    input  logic        BD2,
    input  logic        BD3,
    input  logic        REC_READY,
    output logic        REC_VALID,
    output logic [2:0]  REC_TYPE,
    output logic [4:0]  REC_ADDR,
    output logic [3:0]  REC_DATA,
    output logic        REC_DMA,
    output logic        REC_TMO,
    output logic [7:0]  REC_LEN,
    output logic [3:0]  REC_WAITS,
    output logic        OVF,
    output logic [15:0] CYC_CNT
);
    typedef struct packed {
        logic [2:0] typ;
        logic [4:0] addr;
        logic [3:0] dat;
        logic       dma;
        logic       tmo;
        logic [7:0] len;
        logic [3:0] waits;
    } rec_t;

    typedef enum logic [1:0] {IDLE, ACTIVE, PUSH} state_t;

    state_t     state_q, state_d;
    rec_t       cur_q, cur_d;
    rec_t       cap;
    rec_t       head;
    logic [2:0] cap_type;
    logic       strobe;
    logic       prev_strobe;
    logic       armed;
    logic       start;
    logic       push_vld;
    logic       push_rdy;

    assign strobe = BMREQ_N & IORQ_N;
    // armed stays low after reset until the strobe is seen high, so a cycle
    // already in flight at reset release is never recorded.
    assign start  = !strobe && prev_strobe && armed;

    always_comb begin
        cap_type = 3'd2;
        if (!BMREQ_N) begin
            if (!BRFSH_N)                cap_type = 3'd4;
            else if (!BRD_N && !N_BWR)   cap_type = 3'd0;
            else if (!BM1_N && !BRD_N)   cap_type = 3'd1;
            else if (!BRD_N)             cap_type = 3'd2;
            else if (!N_BWR)             cap_type = 3'd3;
            else                         cap_type = 3'd2;
        end else if (!IORQ_N) begin
            if (!BM1_N)                  cap_type = 3'd7;
            else if (!BRD_N)             cap_type = 3'd5;
            else if (!N_BWR)             cap_type = 3'd6;
            else                         cap_type = 3'd5;
        end
    end

    always_comb begin
        cap.typ   = cap_type;
        cap.addr  = {BA15, BA14, BA13, BA7, BA6};
        cap.dat   = {BD3, BD2, BD1, BD0};
        cap.dma   = !DMA_N;
        cap.tmo   = 1'b0;
        cap.len   = 8'd1;
        cap.waits = {3'b000, !WAIT_N};
    end

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        push_vld = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACTIVE;
                    cur_d   = cap;
                end
            end
            ACTIVE: begin
                if (strobe) begin
                    state_d = PUSH;
                end else if (cur_q.len == 8'hFF) begin
                    cur_d.tmo = 1'b1;
                    state_d   = PUSH;
                end else begin
                    cur_d.len = cur_q.len + 8'd1;
                    if (!WAIT_N && cur_q.waits != 4'hF) begin
                        cur_d.waits = cur_q.waits + 4'd1;
                    end
                end
            end
            PUSH: begin
                push_vld = 1'b1;
                if (start) begin
                    state_d = ACTIVE;
                    cur_d   = cap;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge B_PHI) begin
        if (RST) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            prev_strobe <= 1'b1;
            armed       <= 1'b0;
            OVF         <= 1'b0;
            CYC_CNT     <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            prev_strobe <= strobe;
            armed       <= armed | strobe;
            if (push_vld && !push_rdy) begin
                OVF <= 1'b1;
            end
            if (push_vld && push_rdy) begin
                CYC_CNT <= CYC_CNT + 16'd1;
            end
        end
    end

    sync_fifo #(
        .W     ($bits(rec_t)),
        .DEPTH (4)
    ) u_fifo (
        .clk     (B_PHI),
        .rst     (RST),
        .in_vld  (push_vld),
        .in_rdy  (push_rdy),
        .in_dat  (cur_q),
        .out_vld (REC_VALID),
        .out_rdy (REC_READY),
        .out_dat (head)
    );

    assign REC_TYPE  = head.typ;
    assign REC_ADDR  = head.addr;
    assign REC_DATA  = head.dat;
    assign REC_DMA   = head.dma;
    assign REC_TMO   = head.tmo;
    assign REC_LEN   = head.len;
    assign REC_WAITS = head.waits;
endmodule

// File: tb/tb_z80_bus_decoder.sv
// Bench for z80_bus_decoder: directed vector table, corner sequences, and
// random bus traffic checked every clock against a transaction-level model.
module tb_z80_bus_decoder;
    logic        B_PHI = 1'b0;
    logic        RST, BMREQ_N, IORQ_N, BRD_N, N_BWR, BM1_N, BRFSH_N, WAIT_N, DMA_N;
    logic        BA15, BA14, BA13, BA7, BA6, BD0, BD1, BD2, BD3, REC_READY;
    logic        REC_VALID, REC_DMA, REC_TMO, OVF;
    logic [2:0]  REC_TYPE;
    logic [4:0]  REC_ADDR;
    logic [3:0]  REC_DATA, REC_WAITS;
    logic [7:0]  REC_LEN;
    logic [15:0] CYC_CNT;

    int total = 0;
    int bad   = 0;

    z80_bus_decoder dut (
        .B_PHI(B_PHI), .RST(RST), .BMREQ_N(BMREQ_N), .IORQ_N(IORQ_N), .BRD_N(BRD_N),
        .N_BWR(N_BWR), .BM1_N(BM1_N), .BRFSH_N(BRFSH_N), .WAIT_N(WAIT_N), .DMA_N(DMA_N),
        .BA15(BA15), .BA14(BA14), .BA13(BA13), .BA7(BA7), .BA6(BA6),
        .BD0(BD0), .BD1(BD1), .BD2(BD2), .BD3(BD3), .REC_READY(REC_READY),
        .REC_VALID(REC_VALID), .REC_TYPE(REC_TYPE), .REC_ADDR(REC_ADDR), .REC_DATA(REC_DATA),
        .REC_DMA(REC_DMA), .REC_TMO(REC_TMO), .REC_LEN(REC_LEN), .REC_WAITS(REC_WAITS),
        .OVF(OVF), .CYC_CNT(CYC_CNT)
    );

    always #5 B_PHI = ~B_PHI;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_sync = 0;
    logic [25:0] m_q[$];
    bit          m_ovf, m_pend, m_in, m_prev_hi, m_seen_hi;
    logic [15:0] m_cnt;
    logic [25:0] m_pend_rec;
    logic [2:0]  c_typ;
    logic [4:0]  c_addr;
    logic [3:0]  c_dat;
    bit          c_dma;
    int          c_len, c_waits;

    function automatic logic [2:0] classify(input logic mreq, iorq, rd, wr, m1, rfsh);
        // arguments are active-high "asserted" flags
        if (mreq) begin
            if (rfsh)        return 3'd4;
            if (rd && wr)    return 3'd0;
            if (rd && m1)    return 3'd1;
            if (wr && !rd)   return 3'd3;
            return 3'd2;
        end
        if (m1)              return 3'd7;
        if (wr && !rd)       return 3'd6;
        return 3'd5;
    endfunction

    task automatic model_step();
        bit low;
        if (RST) begin
            m_q.delete();
            m_ovf = 0; m_cnt = 0; m_in = 0; m_pend = 0;
            m_prev_hi = 1; m_seen_hi = 0; m_sync = 1;
            return;
        end
        if (m_q.size() != 0 && REC_READY) void'(m_q.pop_front());
        if (m_pend) begin
            if (m_q.size() < 4) begin
                m_q.push_back(m_pend_rec);
                m_cnt++;
            end else begin
                m_ovf = 1;
            end
            m_pend = 0;
        end
        low = !BMREQ_N || !IORQ_N;
        if (m_in) begin
            if (!low || c_len == 255) begin
                m_pend     = 1;
                m_pend_rec = {c_typ, c_addr, c_dat, c_dma, low, 8'(c_len), 4'(c_waits)};
                m_in       = 0;
            end else begin
                c_len++;
                if (!WAIT_N && c_waits < 15) c_waits++;
            end
        end else if (low && m_prev_hi && m_seen_hi) begin
            m_in    = 1;
            c_typ   = classify(!BMREQ_N, !IORQ_N, !BRD_N, !N_BWR, !BM1_N, !BRFSH_N);
            c_addr  = {BA15, BA14, BA13, BA7, BA6};
            c_dat   = {BD3, BD2, BD1, BD0};
            c_dma   = !DMA_N;
            c_len   = 1;
            c_waits = WAIT_N ? 0 : 1;
        end
        m_prev_hi = !low;
        if (!low) m_seen_hi = 1;
    endtask

    always @(posedge B_PHI) model_step();

    always @(negedge B_PHI) begin
        if (m_sync) begin
            logic [25:0] act_rec, exp_rec;
            act_rec = REC_VALID ? {REC_TYPE, REC_ADDR, REC_DATA, REC_DMA, REC_TMO, REC_LEN, REC_WAITS} : 26'd0;
            exp_rec = (m_q.size() != 0) ? m_q[0] : 26'd0;
            chk("model", {20'd0, REC_VALID, act_rec, OVF, CYC_CNT},
                         {20'd0, m_q.size() != 0, exp_rec, m_ovf, m_cnt});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_bus();
        BMREQ_N = 1; IORQ_N = 1; BRD_N = 1; N_BWR = 1; BM1_N = 1; BRFSH_N = 1; WAIT_N = 1; DMA_N = 1;
    endtask

    task automatic set_bus(input logic mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n, dma_n,
                           input logic [4:0] addr, input logic [3:0] dat);
        BMREQ_N = mreq_n; IORQ_N = iorq_n; BRD_N = rd_n; N_BWR = wr_n;
        BM1_N = m1_n; BRFSH_N = rfsh_n; DMA_N = dma_n;
        {BA15, BA14, BA13, BA7, BA6} = addr;
        {BD3, BD2, BD1, BD0} = dat;
    endtask

    task automatic do_reset();
        RST = 1; REC_READY = 0; idle_bus();
        repeat (2) @(negedge B_PHI);
        RST = 0;
        @(negedge B_PHI);
    endtask

    // one-clock mem read, then returns after the edge that moves the record into the FIFO
    task automatic short_read(input logic [4:0] addr);
        set_bus(0, 1, 0, 1, 1, 1, 1, addr, 4'h0);
        @(negedge B_PHI);
        idle_bus();
        repeat (2) @(negedge B_PHI);
    endtask

    task automatic pop_one();
        REC_READY = 1;
        @(negedge B_PHI);
        REC_READY = 0;
    endtask

    typedef struct {
        logic mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n, dma_n;
        logic [4:0] addr;
        logic [3:0] dat;
        int nclk, nwait;
        logic [2:0] e_type;
        logic [4:0] e_addr;
        logic [3:0] e_dat;
        logic e_dma;
        logic [7:0] e_len;
        logic [3:0] e_waits;
    } vec_t;

    vec_t vt[8];
    int   hold;
    bit   low_phase;
    int   kind;

    initial begin
        //        mreq iorq rd wr m1 rfsh dma  addr      dat  nclk nw  type addr     dat  dma len waits
        vt[0] = '{0, 1, 0, 1, 1, 1, 1, 5'b00001, 4'h0, 1, 0, 3'd2, 5'b00001, 4'h0, 0, 8'd1, 4'd0};
        vt[1] = '{0, 1, 1, 0, 1, 1, 0, 5'b00100, 4'hA, 2, 0, 3'd3, 5'b00100, 4'hA, 1, 8'd2, 4'd0};
        vt[2] = '{0, 1, 0, 1, 1, 0, 1, 5'b01010, 4'h3, 5, 3, 3'd4, 5'b01010, 4'h3, 0, 8'd5, 4'd3};
        vt[3] = '{1, 0, 1, 0, 1, 1, 1, 5'b10001, 4'h5, 3, 1, 3'd6, 5'b10001, 4'h5, 0, 8'd3, 4'd1};
        vt[4] = '{0, 1, 0, 0, 1, 1, 1, 5'b00011, 4'h9, 1, 1, 3'd0, 5'b00011, 4'h9, 0, 8'd1, 4'd1};
        vt[5] = '{0, 1, 0, 1, 0, 1, 1, 5'b11111, 4'hF, 4, 4, 3'd1, 5'b11111, 4'hF, 0, 8'd4, 4'd4};
        vt[6] = '{1, 0, 1, 1, 0, 1, 1, 5'b01100, 4'h6, 2, 0, 3'd7, 5'b01100, 4'h6, 0, 8'd2, 4'd0};
        vt[7] = '{1, 0, 0, 1, 1, 1, 0, 5'b10110, 4'hC, 2, 2, 3'd5, 5'b10110, 4'hC, 1, 8'd2, 4'd2};

        RST = 1; REC_READY = 0; idle_bus(); set_bus(1, 1, 1, 1, 1, 1, 1, 5'd0, 4'd0);
        repeat (2) @(negedge B_PHI);
        chk("reset_valid", REC_VALID, 0);
        chk("reset_ovf", OVF, 0);
        chk("reset_cnt", CYC_CNT, 0);
        chk("reset_rec", {REC_TYPE, REC_ADDR, REC_DATA, REC_DMA, REC_TMO, REC_LEN, REC_WAITS}, 0);
        RST = 0;
        @(negedge B_PHI);

        // directed vector table
        for (int v = 0; v < 8; v++) begin
            set_bus(vt[v].mreq_n, vt[v].iorq_n, vt[v].rd_n, vt[v].wr_n, vt[v].m1_n,
                    vt[v].rfsh_n, vt[v].dma_n, vt[v].addr, vt[v].dat);
            for (int k = 0; k < vt[v].nclk; k++) begin
                WAIT_N = (k >= vt[v].nwait);
                @(negedge B_PHI);
            end
            idle_bus();
            @(negedge B_PHI);
            chk($sformatf("vec%0d_latency_not_yet", v), REC_VALID, 0);
            @(negedge B_PHI);
            chk($sformatf("vec%0d_valid", v), REC_VALID, 1);
            chk($sformatf("vec%0d_record", v),
                {REC_TYPE, REC_ADDR, REC_DATA, REC_DMA, REC_TMO, REC_LEN, REC_WAITS},
                {vt[v].e_type, vt[v].e_addr, vt[v].e_dat, vt[v].e_dma, 1'b0, vt[v].e_len, vt[v].e_waits});
            if (v == 0) chk("vec0_cyc_cnt", CYC_CNT, 1);
            pop_one();
            chk($sformatf("vec%0d_drained", v), REC_VALID, 0);
        end

        // overflow: six cycles, nothing popped
        do_reset();
        for (int i = 0; i < 6; i++) short_read(5'(i + 1));
        chk("ovf_flag", OVF, 1);
        chk("ovf_cnt", CYC_CNT, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ovf_drain%0d", i), {REC_VALID, REC_ADDR}, {1'b1, 5'(i + 1)});
            pop_one();
        end
        chk("ovf_empty", REC_VALID, 0);

        // full FIFO with pop on the push edge
        do_reset();
        for (int i = 0; i < 4; i++) short_read(5'(i + 1));
        set_bus(0, 1, 0, 1, 1, 1, 1, 5'd5, 4'h0);
        @(negedge B_PHI);
        idle_bus();
        @(negedge B_PHI);
        REC_READY = 1;
        @(negedge B_PHI);
        REC_READY = 0;
        chk("fullpop_cnt", CYC_CNT, 5);
        chk("fullpop_ovf", OVF, 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fullpop_drain%0d", i), {REC_VALID, REC_ADDR}, {1'b1, 5'(i + 2)});
            pop_one();
        end

        // back-to-back: new start on the push edge
        do_reset();
        set_bus(0, 1, 0, 1, 1, 1, 1, 5'd6, 4'h0);
        @(negedge B_PHI);
        idle_bus();
        @(negedge B_PHI);
        set_bus(0, 1, 0, 1, 1, 1, 1, 5'd7, 4'h0);
        @(negedge B_PHI);
        idle_bus();
        repeat (2) @(negedge B_PHI);
        chk("b2b_cnt", CYC_CNT, 2);
        chk("b2b_first", REC_ADDR, 6);
        pop_one();
        chk("b2b_second", {REC_VALID, REC_ADDR}, {1'b1, 5'd7});
        pop_one();

        // timeout
        do_reset();
        set_bus(0, 1, 0, 1, 1, 1, 1, 5'd3, 4'h0);
        repeat (300) @(negedge B_PHI);
        idle_bus();
        repeat (3) @(negedge B_PHI);
        chk("tmo_cnt", CYC_CNT, 1);
        chk("tmo_rec", {REC_VALID, REC_TMO, REC_LEN}, {1'b1, 1'b1, 8'd255});
        pop_one();
        chk("tmo_no_second", {REC_VALID, CYC_CNT}, {1'b0, 16'd1});

        // reset mid-cycle, strobe still low at release
        do_reset();
        set_bus(0, 1, 0, 1, 1, 1, 1, 5'd9, 4'h0);
        repeat (10) @(negedge B_PHI);
        RST = 1;
        @(negedge B_PHI);
        RST = 0;
        repeat (5) @(negedge B_PHI);
        chk("rstmid_nothing", {REC_VALID, CYC_CNT}, 0);
        idle_bus();
        repeat (2) @(negedge B_PHI);
        chk("rstmid_still_nothing", {REC_VALID, CYC_CNT}, 0);
        short_read(5'd9);
        chk("rstmid_next_recorded", {REC_VALID, CYC_CNT, REC_ADDR}, {1'b1, 16'd1, 5'd9});
        pop_one();

        // random traffic, checked by the per-clock model comparison
        do_reset();
        hold = 0; low_phase = 0; kind = 0;
        for (int n = 0; n < 4000; n++) begin
            if (hold == 0) begin
                low_phase = !low_phase;
                if (low_phase) begin
                    hold = ($urandom_range(0, 99) == 0) ? $urandom_range(250, 270) : $urandom_range(1, 8);
                    kind = $urandom_range(0, 2);
                end else begin
                    hold = $urandom_range(1, 3);
                end
            end
            hold--;
            BMREQ_N = !(low_phase && kind != 1);
            IORQ_N  = !(low_phase && kind != 0);
            BRD_N   = 1'($urandom_range(0, 1));
            N_BWR   = 1'($urandom_range(0, 1));
            BM1_N   = 1'($urandom_range(0, 1));
            BRFSH_N = ($urandom_range(0, 3) != 0);
            WAIT_N  = 1'($urandom_range(0, 1));
            DMA_N   = 1'($urandom_range(0, 1));
            {BA15, BA14, BA13, BA7, BA6} = 5'($urandom);
            {BD3, BD2, BD1, BD0} = 4'($urandom);
            REC_READY = ($urandom_range(0, 9) < 3);
            RST = ($urandom_range(0, 999) == 0);
            @(negedge B_PHI);
        end
        RST = 0;
        idle_bus();
        REC_READY = 1;
        repeat (10) @(negedge B_PHI);
        chk("final_drained", REC_VALID, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/z80_bus_decoder.md
Z80_BUS_DECODER -- requirements
Module: z80_bus_decoder

Interface
REQ-001 The block SHALL use one clock and a reset that is synchronous and active-high.
REQ-002 B_PHI  in  1  Z80 clock; all inputs are sampled on its rising edge.
REQ-003 RST  in  1  synchronous active-high reset.
REQ-004 BMREQ_N, IORQ_N, BRD_N, N_BWR, BM1_N, BRFSH_N, WAIT_N, DMA_N  in  1 each  buffered Z80 bus strobes, all active low.
REQ-005 BA15, BA14, BA13, BA7, BA6  in  1 each  buffered address lines.
REQ-006 BD0..BD3  in  1 each  buffered data lines.
REQ-007 REC_READY  in  1  consumer accepts the head record.
REQ-008 REC_VALID  out  1  head record present.
REQ-009 REC_TYPE  out  3  cycle class (REQ-014).
REQ-010 REC_ADDR  out  5  {BA15,BA14,BA13,BA7,BA6} captured at cycle start.
REQ-011 REC_DATA  out  4  {BD3..BD0} captured at cycle start.
REQ-012 REC_DMA, REC_TMO  out  1 each  DMA_N low at start; cycle timed out.
REQ-013 REC_LEN  out  8  strobe-low cycle count; REC_WAITS  out  4  WAIT_N-low cycle count; OVF  out  1  sticky drop flag; CYC_CNT  out  16  records pushed.

Function
REQ-014 Type encoding: 0=conflict (BRD_N and N_BWR both low with BMREQ_N low); 1=M1 fetch (BMREQ_N, BM1_N, BRD_N low); 2=mem read; 3=mem write; 4=refresh (BMREQ_N and BRFSH_N low, taking priority over read and write); 5=IO read; 6=IO write; 7=interrupt ack (IORQ_N and BM1_N low).
REQ-015 The strobe is BMREQ_N AND IORQ_N (active when either is low); prev_strobe is a registered copy of the strobe.
REQ-016 A cycle starts only on the first rising edge where the strobe is low and prev_strobe is high.
REQ-017 The FSM SHALL have states IDLE, ACTIVE and PUSH.
REQ-018 IDLE->ACTIVE on cycle start; capture type, address, data and DMA; set LEN=1 and WAITS = (WAIT_N==0).
REQ-019 In ACTIVE, each edge with the strobe low increments LEN and increments WAITS when WAIT_N is low; both saturate (255 and 15).
REQ-020 ACTIVE->PUSH on the first edge with the strobe high.
REQ-021 ACTIVE->PUSH with TMO=1 when LEN reaches 255 and the strobe is still low.
REQ-022 After a timeout, no new start occurs until the strobe is seen high (REQ-016).
REQ-023 PUSH writes the record into the FIFO on that edge and returns to IDLE.
REQ-024 A strobe falling edge sampled during PUSH is a valid start; the block goes PUSH->ACTIVE directly, with no lost cycle.
REQ-025 FIFO depth is 4; REC_* fields present the head entry.
REQ-026 REC_VALID=1 whenever the FIFO is non-empty.
REQ-027 A pop occurs on an edge where REC_VALID and REC_READY are both 1.
REQ-028 Latency: strobe high sampled at edge N -> REC_VALID=1 after edge N+1 when the FIFO was empty.
REQ-029 When full, a push without a same-edge pop is dropped: OVF is set and CYC_CNT is unchanged.
REQ-030 When full, a push with a same-edge pop succeeds and the occupancy stays 4.
REQ-031 A simultaneous push and pop when the FIFO is empty SHALL leave 1 entry, because the push lands after the pop of nothing.
REQ-032 CYC_CNT increments on each accepted push and wraps from 0xFFFF to 0.
REQ-033 REC_* outputs are don't-care while REC_VALID=0 but SHALL hold stable while REC_VALID=1 and REC_READY=0.

Reset
REQ-034 On RST=1 the FSM SHALL go to IDLE, the FIFO SHALL empty, and REC_VALID, OVF and CYC_CNT SHALL be 0.
REQ-035 On RST=1 prev_strobe SHALL be 1, LEN and WAITS SHALL be 0, and all REC_* SHALL be 0.
REQ-036 Reset asserted mid-cycle SHALL discard the partial record.
REQ-037 If the strobe is already low when RST is released, that cycle SHALL NOT be recorded.

Verification
REQ-038 Mem read: BMREQ_N/BRD_N low for 1 clock, BA7:BA6=01, other BA=0 -> one record TYPE=2, ADDR=00001, LEN=1, WAITS=0, DMA=0, CYC_CNT=1.
REQ-039 DMA mem write: DMA_N=0, N_BWR=0, BA13=1, BD=1010 -> record TYPE=3, ADDR=00100, DATA=1010, DMA=1.
REQ-040 Refresh plus read with WAIT_N low for 3 of 5 strobe clocks -> TYPE=4, LEN=5, WAITS=3.
REQ-041 IO write (IORQ_N=0, N_BWR=0, BA15=1, BA6=1) -> TYPE=6, ADDR=10001; BRD_N and N_BWR both low with BMREQ_N low -> TYPE=0.
REQ-042 Overflow: 6 cycles with REC_READY=0 -> 4 records held, OVF=1, CYC_CNT=4; draining returns the first 4 in order.
REQ-043 Timeout and reset: strobe held low for 300 clocks -> one record with TMO=1 and LEN=255, and no second record; RST pulsed at LEN=10 of a new cycle -> FIFO empty and nothing recorded until the strobe returns high.
